// File: rtl/online_operand_sequencer_pkg.sv
// Shared definitions for the online operand sequencer.
//   - state_e    : FSM states; the encoding doubles as the STATES output code
//   - DIGIT_W    : width of one emitted digit group
//   - canon_group: clears every digit position written as plus=1/minus=1
package online_operand_sequencer_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b10,
      ST_RUN   = 2'b01,
      ST_FLUSH = 2'b11
   } state_e;

   // Returns {plus, minus} with redundant 1-1 zero digits rewritten as 0-0.
   function automatic logic [2*DIGIT_W-1:0] canon_group(input logic [DIGIT_W-1:0] p,
                                                        input logic [DIGIT_W-1:0] m);
      logic [DIGIT_W-1:0] zero_pair;
      zero_pair = p & m;
      return {p & ~zero_pair, m & ~zero_pair};
   endfunction

endpackage

// File: rtl/online_operand_sequencer_operand_group_shifter.sv
// operand_group_shifter: holds one plus/minus operand pair and presents it
// one DIGIT_W group per cycle, most significant group first, through a
// registered output.
//   clk, rst            : clock, async active-high reset
//   load_i              : capture plus_i/minus_i and emit their top group
//   shift_i             : emit the next stored group
//   clear_i             : drive the group outputs to zero
//   plus_i, minus_i     : parallel operand strings
//   plus_o, minus_o     : current digit group (registered)
// Build option: DIGIT_CANON_EN canonicalises each emitted group.
module operand_group_shifter
   import online_operand_sequencer_pkg::*;
#(
   parameter int NUM_GROUPS = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load_i,
   input  logic                            shift_i,
   input  logic                            clear_i,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   plus_i,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   minus_i,
   output logic [DIGIT_W-1:0]              plus_o,
   output logic [DIGIT_W-1:0]              minus_o
);

   localparam int W = DIGIT_W * NUM_GROUPS;

   logic [W-1:0]         plus_q, minus_q;
   logic [W-1:0]         src_plus, src_minus;
   logic [DIGIT_W-1:0]   plus_out_q, minus_out_q;
   logic [2*DIGIT_W-1:0] group_d;

   // The stored string already has the emitted group shifted out, so the
   // next group to emit always sits at the top.
   always_comb begin
      src_plus  = load_i ? plus_i  : plus_q;
      src_minus = load_i ? minus_i : minus_q;
`ifdef DIGIT_CANON_EN
      group_d = canon_group(src_plus[W-1 -: DIGIT_W], src_minus[W-1 -: DIGIT_W]);
`else
      group_d = {src_plus[W-1 -: DIGIT_W], src_minus[W-1 -: DIGIT_W]};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         plus_q      <= '0;
         minus_q     <= '0;
         plus_out_q  <= '0;
         minus_out_q <= '0;
      end else if (load_i || shift_i) begin
         plus_q      <= src_plus  << DIGIT_W;
         minus_q     <= src_minus << DIGIT_W;
         plus_out_q  <= group_d[2*DIGIT_W-1:DIGIT_W];
         minus_out_q <= group_d[DIGIT_W-1:0];
      end else if (clear_i) begin
         plus_out_q  <= '0;
         minus_out_q <= '0;
      end
   end

   assign plus_o  = plus_out_q;
   assign minus_o = minus_out_q;

endmodule

// File: rtl/online_operand_sequencer.sv
// online_operand_sequencer: accepts a redundant X/Y operand pair through a
// valid/ready handshake and streams it MSD group first, one group per clock,
// followed by DELTA zero-digit flush cycles, with a STATES phase code.
//   clk, rst                        : clock, async active-high reset
//   in_valid / in_ready             : operand handshake (in_ready combinational)
//   op_{x,y}_{plus,minus}           : parallel operand digit strings
//   {x,y}_{plus,minus}              : current digit group (registered)
//   STATES                          : 00 idle, 10 load, 01 run, 11 flush
//   digit_idx                       : cycle index within the operation
//   done                            : pulse on the final emitted cycle
// Build option: DIGIT_CANON_EN canonicalises emitted groups (1-1 -> 0-0).
//
// state    | meaning
// ST_IDLE  | waiting for an operand pair, outputs zero
// ST_LOAD  | emitting the most significant group
// ST_RUN   | emitting the remaining groups
// ST_FLUSH | emitting zero digits for the online delay
module online_operand_sequencer
   import online_operand_sequencer_pkg::*;
#(
   parameter  int NUM_GROUPS = 4,
   parameter  int DELTA      = 2,
   localparam int TOTAL      = NUM_GROUPS + DELTA,
   localparam int IDX_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   op_x_plus,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   op_x_minus,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   op_y_plus,
   input  logic [DIGIT_W*NUM_GROUPS-1:0]   op_y_minus,
   output logic [DIGIT_W-1:0]              x_plus,
   output logic [DIGIT_W-1:0]              x_minus,
   output logic [DIGIT_W-1:0]              y_plus,
   output logic [DIGIT_W-1:0]              y_minus,
   output logic [1:0]                      STATES,
   output logic [IDX_W-1:0]                digit_idx,
   output logic                            done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
   localparam logic [IDX_W-1:0] RUN_LAST = IDX_W'(NUM_GROUPS - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q;
   logic             accept, busy, last, shift, clear;

   always_comb begin
      busy   = (state_q != ST_IDLE);
      accept = !busy && in_valid;
      last   = busy && (idx_q == LAST_IDX);
      // Another operand group remains while the index is below the last
      // group position; everything after that is flush or the IDLE return.
      shift  = busy && (idx_q < RUN_LAST);
      clear  = busy && !shift;
      idx_d  = idx_q + IDX_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q <= ST_LOAD;
                  idx_q   <= '0;
                  done_q  <= (TOTAL == 1);
               end
            end
            default: begin
               if (last) begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
                  done_q  <= 1'b0;
               end else begin
                  state_q <= shift ? ST_RUN : ST_FLUSH;
                  idx_q   <= idx_d;
                  done_q  <= (idx_d == LAST_IDX);
               end
            end
         endcase
      end
   end

   operand_group_shifter #(.NUM_GROUPS(NUM_GROUPS)) u_x_shifter (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (shift),
      .clear_i (clear),
      .plus_i  (op_x_plus),
      .minus_i (op_x_minus),
      .plus_o  (x_plus),
      .minus_o (x_minus)
   );

   operand_group_shifter #(.NUM_GROUPS(NUM_GROUPS)) u_y_shifter (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (shift),
      .clear_i (clear),
      .plus_i  (op_y_plus),
      .minus_i (op_y_minus),
      .plus_o  (y_plus),
      .minus_o (y_minus)
   );

   assign in_ready  = !busy;
   assign STATES    = state_q;
   assign digit_idx = idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_online_operand_sequencer.sv
// Testbench for online_operand_sequencer: a cycle model derived from the
// operation's digit-schedule rules is checked every cycle against the default
// N=4/D=2 instance, with literal checks on the basic sequence, handshake,
// reset abort, canonicalisation and two N=1 instances.
module tb_online_operand_sequencer;

   typedef struct packed {
      logic [1:0] st;
      logic       dn;
      logic [3:0] xp, xm, yp, ym;
   } exp_t;

   int n_vec = 0;
   int n_err = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // main instance, N=4 D=2
   logic        in_valid = 1'b0;
   logic [15:0] oxp = '0, oxm = '0, oyp = '0, oym = '0;
   logic        in_ready, done;
   logic [3:0]  xp, xm, yp, ym;
   logic [1:0]  states;
   logic [2:0]  idx;

   // N=1 D=0
   logic        v1 = 1'b0;
   logic [3:0]  a1 = '0, b1 = '0, c1 = '0, d1 = '0;
   logic        rdy1, dn1;
   logic [3:0]  xp1, xm1, yp1, ym1;
   logic [1:0]  st1;
   logic [0:0]  idx1;

   // N=1 D=2
   logic        v2 = 1'b0;
   logic [3:0]  a2 = '0, b2 = '0, c2 = '0, d2 = '0;
   logic        rdy2, dn2;
   logic [3:0]  xp2, xm2, yp2, ym2;
   logic [1:0]  st2;
   logic [1:0]  idx2;

   online_operand_sequencer #(.NUM_GROUPS(4), .DELTA(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_x_plus(oxp), .op_x_minus(oxm), .op_y_plus(oyp), .op_y_minus(oym),
      .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym),
      .STATES(states), .digit_idx(idx), .done(done)
   );

   online_operand_sequencer #(.NUM_GROUPS(1), .DELTA(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
      .op_x_plus(a1), .op_x_minus(b1), .op_y_plus(c1), .op_y_minus(d1),
      .x_plus(xp1), .x_minus(xm1), .y_plus(yp1), .y_minus(ym1),
      .STATES(st1), .digit_idx(idx1), .done(dn1)
   );

   online_operand_sequencer #(.NUM_GROUPS(1), .DELTA(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
      .op_x_plus(a2), .op_x_minus(b2), .op_y_plus(c2), .op_y_minus(d2),
      .x_plus(xp2), .x_minus(xm2), .y_plus(yp2), .y_minus(ym2),
      .STATES(st2), .digit_idx(idx2), .done(dn2)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expected outputs for cycle k of an operation, straight from the schedule:
   // cycle 0 is the MSD group, cycles 1..n-1 the rest, then d zero cycles.
   function automatic exp_t exp_vec(input int n, input int d, input int k,
                                    input logic [63:0] x_p, input logic [63:0] x_m,
                                    input logic [63:0] y_p, input logic [63:0] y_m);
      exp_t e;
      int sh;
      logic [3:0] z;
      e = '0;
      e.st = (k == 0) ? 2'b10 : ((k < n) ? 2'b01 : 2'b11);
      e.dn = (k == n + d - 1);
      if (k < n) begin
         sh = 4 * (n - 1 - k);
         e.xp = 4'((x_p >> sh) & 64'hF);
         e.xm = 4'((x_m >> sh) & 64'hF);
         e.yp = 4'((y_p >> sh) & 64'hF);
         e.ym = 4'((y_m >> sh) & 64'hF);
`ifdef DIGIT_CANON_EN
         z = e.xp & e.xm; e.xp = e.xp & ~z; e.xm = e.xm & ~z;
         z = e.yp & e.ym; e.yp = e.yp & ~z; e.ym = e.ym & ~z;
`else
         z = '0;
`endif
      end
      return e;
   endfunction

   // Model of the main instance: busy for exactly 6 cycles after an accept.
   bit          m_busy = 1'b0;
   int          m_k = 0;
   logic [63:0] m_xp = '0, m_xm = '0, m_yp = '0, m_ym = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_k    <= 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_xp   <= 64'(oxp);
            m_xm   <= 64'(oxm);
            m_yp   <= 64'(oyp);
            m_ym   <= 64'(oym);
         end
      end else if (m_k == 5) begin
         m_busy <= 1'b0;
         m_k    <= 0;
      end else begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin : cmp
      exp_t e;
      int   ei;
      e  = m_busy ? exp_vec(4, 2, m_k, m_xp, m_xm, m_yp, m_ym) : '0;
      ei = m_busy ? m_k : 0;
      chk("m_states", 64'(states), 64'(e.st));
      chk("m_done",   64'(done),   64'(e.dn));
      chk("m_idx",    64'(idx),    64'(ei));
      chk("m_ready",  64'(in_ready), 64'(!m_busy));
      chk("m_xp", 64'(xp), 64'(e.xp));
      chk("m_xm", 64'(xm), 64'(e.xm));
      chk("m_yp", 64'(yp), 64'(e.yp));
      chk("m_ym", 64'(ym), 64'(e.ym));
   end

   logic [1:0] t1_st [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
   logic [3:0] t1_xp [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0};
`ifdef DIGIT_CANON_EN
   logic [3:0] t1_yp [6] = '{4'hA, 4'h0, 4'hA, 4'h5, 4'h0, 4'h0};
   logic [3:0] t1_ym [6] = '{4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] t5_xp [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
   logic [3:0] t5_xm [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
`else
   logic [3:0] t1_yp [6] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'h0};
   logic [3:0] t1_ym [6] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] t5_xp [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
   logic [3:0] t5_xm [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
`endif

   initial begin : stim
      int loads[$];

      // reset state
      #1;
      chk("rst_states", 64'(states), 64'd0);
      chk("rst_ready",  64'(in_ready), 64'd1);
      chk("rst_idx",    64'(idx), 64'd0);
      chk("rst_done",   64'(done), 64'd0);
      chk("rst_xp",     64'(xp), 64'd0);
      in_valid = 1'b1;
      repeat (2) tick();
      chk("rst_ignore_valid", 64'(states), 64'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      tick();

      // basic sequence
      oxp = 16'h1234; oxm = 16'h0000; oyp = 16'hA5A5; oym = 16'h0F00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t1_states", 64'(states), 64'(t1_st[c]));
         chk("t1_xp", 64'(xp), 64'(t1_xp[c]));
         chk("t1_yp", 64'(yp), 64'(t1_yp[c]));
         chk("t1_ym", 64'(ym), 64'(t1_ym[c]));
         chk("t1_done", 64'(done), 64'(c == 5));
         chk("t1_idx", 64'(idx), 64'(c));
      end
      @(negedge clk);
      chk("t1_idle_states", 64'(states), 64'd0);
      chk("t1_idle_ready", 64'(in_ready), 64'd1);
      tick();

      // handshake: in_valid held high, operands change every cycle
      in_valid = 1'b1;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (states == 2'b10) loads.push_back(c);
         @(posedge clk);
         #2;
         oxp = 16'($urandom); oxm = 16'($urandom);
         oyp = 16'($urandom); oym = 16'($urandom);
      end
      in_valid = 1'b0;
      chk("hs_n_loads", 64'(loads.size()), 64'd3);
      if (loads.size() >= 3) begin
         chk("hs_interval0", 64'(loads[1] - loads[0]), 64'd7);
         chk("hs_interval1", 64'(loads[2] - loads[1]), 64'd7);
      end
      repeat (8) tick();

      // reset during RUN
      oxp = 16'h1234; oxm = 16'h0000; oyp = 16'hA5A5; oym = 16'h0F00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("rr_in_run", 64'(states), 64'b01);
      chk("rr_idx2", 64'(idx), 64'd2);
      rst = 1'b1;
      in_valid = 1'b1;
      oxp = 16'hC0DE; oyp = 16'h7777;
      #1;
      chk("rr_states", 64'(states), 64'd0);
      chk("rr_xp", 64'(xp), 64'd0);
      chk("rr_yp", 64'(yp), 64'd0);
      chk("rr_idx", 64'(idx), 64'd0);
      chk("rr_done", 64'(done), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      chk("rr_restart_states", 64'(states), 64'b10);
      chk("rr_restart_xp", 64'(xp), 64'hC);
      chk("rr_restart_yp", 64'(yp), 64'h7);
      repeat (7) tick();

      // canonicalisation pattern
      oxp = 16'hFFFF; oxm = 16'h0F0F; oyp = 16'h0000; oym = 16'h0000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t5_xp", 64'(xp), 64'(t5_xp[c]));
         chk("t5_xm", 64'(xm), 64'(t5_xm[c]));
      end
      repeat (4) tick();

      // N=1 D=0: single LOAD cycle carrying done
      a1 = 4'h9; b1 = 4'h6; c1 = 4'hA; d1 = 4'h5;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      chk("n1d0_states", 64'(st1), 64'b10);
      chk("n1d0_done", 64'(dn1), 64'd1);
      chk("n1d0_xp", 64'(xp1), 64'h9);
      chk("n1d0_xm", 64'(xm1), 64'h6);
      chk("n1d0_yp", 64'(yp1), 64'hA);
      chk("n1d0_ym", 64'(ym1), 64'h5);
      chk("n1d0_idx", 64'(idx1), 64'd0);
      chk("n1d0_ready", 64'(rdy1), 64'd0);
      tick();
      chk("n1d0_idle", 64'(st1), 64'd0);
      chk("n1d0_done_off", 64'(dn1), 64'd0);
      chk("n1d0_xp_off", 64'(xp1), 64'd0);
      chk("n1d0_ready_back", 64'(rdy1), 64'd1);

      // N=1 D=2: LOAD, FLUSH, FLUSH(done)
      a2 = 4'h9; b2 = 4'h6; c2 = 4'hA; d2 = 4'h5;
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      chk("n1d2_c0_states", 64'(st2), 64'b10);
      chk("n1d2_c0_xp", 64'(xp2), 64'h9);
      chk("n1d2_c0_done", 64'(dn2), 64'd0);
      tick();
      chk("n1d2_c1_states", 64'(st2), 64'b11);
      chk("n1d2_c1_xp", 64'(xp2), 64'h0);
      chk("n1d2_c1_ym", 64'(ym2), 64'h0);
      chk("n1d2_c1_idx", 64'(idx2), 64'd1);
      chk("n1d2_c1_done", 64'(dn2), 64'd0);
      tick();
      chk("n1d2_c2_states", 64'(st2), 64'b11);
      chk("n1d2_c2_idx", 64'(idx2), 64'd2);
      chk("n1d2_c2_done", 64'(dn2), 64'd1);
      tick();
      chk("n1d2_idle", 64'(st2), 64'd0);
      chk("n1d2_idle_idx", 64'(idx2), 64'd0);
      chk("n1d2_ready", 64'(rdy2), 64'd1);

      // randomized traffic with occasional resets, checked by the model
      for (int c = 0; c < 400; c++) begin
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 59) == 0) rst = 1'b1;
         in_valid = ($urandom_range(0, 2) != 0);
         oxp = 16'($urandom); oxm = 16'($urandom);
         oyp = 16'($urandom); oym = 16'($urandom);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
